// File: rtl/opl2_pkg.sv
// opl2_pkg: shared state type, chip timing constants and write record for the OPL2 write scheduler
package opl2_pkg;
    typedef enum logic [2:0] {IDLE, ADDR_PH, ADDR_WAIT, DATA_PH, DATA_WAIT} sched_state_t;
    localparam int OPL2_ADDR_WAIT_US = 4;
    localparam int OPL2_DATA_WAIT_US = 23;
    localparam int OPL2_CLK_DIV = 70;
    typedef struct packed {
        logic [7:0] regn;
        logic [7:0] data;
        logic       src;
    } opl2_wr_t;
    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/opl2_write_sched_if.sv
// opl2_write_sched_if: requester handshakes plus the OPL2 two-phase write port
interface opl2_write_sched_if;
    logic       req0_valid;
    logic [7:0] req0_reg;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_reg;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       opl_addr;
    logic [7:0] opl_din;
    logic       opl_we;
    logic       busy;
    logic       wr_done;
    logic       wr_src;
    modport master (
        output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready, opl_addr, opl_din, opl_we, busy, wr_done, wr_src
    );
    modport slave (
        input  req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready, opl_addr, opl_din, opl_we, busy, wr_done, wr_src
    );
endinterface

// File: rtl/opl2_rr_arb2.sv
// opl2_rr_arb2: two-requester round-robin grant; pointer moves to the loser on every accept
module opl2_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic ptr;
    assign grant[0] = en & valid[0] & (~valid[1] | ~ptr);
    assign grant[1] = en & valid[1] & (~valid[0] | ptr);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= 1'b0;
        else if (|grant) ptr <= grant[0];
    end
endmodule

// File: rtl/opl2_write_sched.sv
// opl2_write_sched: arbitrates two register-write requesters onto the OPL2 address/data port
// with strobe phases and the chip's mandatory wait times between them.
module opl2_write_sched
    import opl2_pkg::*;
#(
    parameter int CLK_DIV      = OPL2_CLK_DIV,
    parameter int WE_CYCLES    = 2,
    parameter int ADDR_WAIT_US = OPL2_ADDR_WAIT_US,
    parameter int DATA_WAIT_US = OPL2_DATA_WAIT_US
) (
    input logic clk,
    input logic rst,
    opl2_write_sched_if.slave bus
);
    localparam int ADDR_CYC = imax(1, ADDR_WAIT_US * CLK_DIV);
    localparam int DATA_CYC = imax(1, DATA_WAIT_US * CLK_DIV);
    localparam int WAIT_W = $clog2(imax(ADDR_WAIT_US, DATA_WAIT_US) * CLK_DIV + 1);
    // the same counter times the strobe phases, so it must also hold WE_CYCLES-1
    localparam int CNT_W = imax(imax(WAIT_W, $clog2(WE_CYCLES + 1)), 1);
    localparam logic [CNT_W-1:0] LD_WE = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_AW = CNT_W'(ADDR_CYC - 1);
    localparam logic [CNT_W-1:0] LD_DW = CNT_W'(DATA_CYC - 1);

    sched_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    opl2_wr_t         wr, win;
    logic [1:0]       grant;
    logic             accept, last, out_addr, done;

    opl2_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state == IDLE && !rst),
        .valid ({bus.req1_valid, bus.req0_valid}),
        .grant (grant)
    );

    assign accept = |grant;
    assign last = cnt == '0;
    assign win = grant[1] ? '{regn: bus.req1_reg, data: bus.req1_data, src: 1'b1}
                          : '{regn: bus.req0_reg, data: bus.req0_data, src: 1'b0};

    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt - CNT_W'(1);
        done = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = accept ? ADDR_PH : IDLE;
                cnt_nxt = accept ? LD_WE : '0;
            end
            ADDR_PH: if (last) begin
                state_nxt = ADDR_WAIT;
                cnt_nxt = LD_AW;
            end
            ADDR_WAIT: if (last) begin
                state_nxt = DATA_PH;
                cnt_nxt = LD_WE;
            end
            DATA_PH: if (last) begin
                state_nxt = DATA_WAIT;
                cnt_nxt = LD_DW;
            end
            DATA_WAIT: if (last) begin
                state_nxt = IDLE;
                cnt_nxt = '0;
                done = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    // out_addr selects which latched byte drives the bus and keeps it after the sequence ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            wr <= '0;
            out_addr <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            if (accept) begin
                wr <= win;
                out_addr <= 1'b0;
            end else if (state == ADDR_WAIT && last) begin
                out_addr <= 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.opl_we = state == ADDR_PH || state == DATA_PH;
    assign bus.opl_addr = out_addr;
    assign bus.opl_din = out_addr ? wr.data : wr.regn;
    assign bus.busy = state != IDLE;
    assign bus.wr_done = done;
    assign bus.wr_src = done & wr.src;
endmodule

// File: tb/tb_opl2_write_sched.sv
// tb_opl2_write_sched: table vectors, directed timing/arbitration/reset sequences and a
// randomized run, all compared against a timeline reference model of each instance.
module tb_opl2_write_sched;
    localparam int A_CYC = 4 * 70;
    localparam int D_CYC = 23 * 70;

    typedef struct {
        int         k;
        logic       ptr;
        logic [7:0] r;
        logic [7:0] d;
        logic       s;
        logic       ha;
        logic [7:0] hd;
    } mdl_t;

    typedef struct packed {
        logic       busy;
        logic       we;
        logic       addr;
        logic [7:0] din;
        logic       done;
        logic       src;
        logic       rdy0;
        logic       rdy1;
    } obs_t;

    typedef struct {
        logic       v;
        logic [7:0] r;
        logic [7:0] d;
        logic       rdy;
        logic       we;
        logic       addr;
        logic [7:0] din;
        logic       done;
        logic       busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    mdl_t ma, mz;
    logic pa_we, pa_addr, pz_we, pz_addr;
    logic [7:0] pa_din, pz_din;

    opl2_write_sched_if ifa ();
    opl2_write_sched_if ifz ();

    opl2_write_sched dut (.clk(clk), .rst(rst), .bus(ifa));
    opl2_write_sched #(.WE_CYCLES(1), .ADDR_WAIT_US(0), .DATA_WAIT_US(0)) dz (.clk(clk), .rst(rst), .bus(ifz));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", n, $time, act, exp);
        end
    endtask

    function automatic mdl_t mdl_zero();
        mdl_t m;
        m.k = 0; m.ptr = 1'b0; m.r = '0; m.d = '0; m.s = 1'b0; m.ha = 1'b0; m.hd = '0;
        return m;
    endfunction

    function automatic int pick(input mdl_t m, input logic r, input logic v0, input logic v1);
        if (r || m.k != 0) return -1;
        if (v0 && v1) return m.ptr ? 1 : 0;
        return v0 ? 0 : (v1 ? 1 : -1);
    endfunction

    // timeline of one write: k counts cycles since the accept cycle
    function automatic obs_t expect_of(input mdl_t m, input int w, input int a, input int d, input int wn);
        obs_t o;
        o = '0;
        o.rdy0 = wn == 0;
        o.rdy1 = wn == 1;
        if (m.k == 0) begin
            o.addr = m.ha;
            o.din = m.hd;
        end else begin
            o.busy = 1'b1;
            o.addr = m.k > w + a;
            o.din = o.addr ? m.d : m.r;
            o.we = m.k <= w || (o.addr && m.k <= 2 * w + a);
            o.done = m.k == 2 * w + a + d;
            o.src = o.done & m.s;
        end
        return o;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int w, input int a, input int d, input logic r,
                                  input int wn, input logic [7:0] r0, d0, r1, d1);
        if (r) return mdl_zero();
        if (wn >= 0) begin
            m.k = 1;
            m.ptr = wn == 0;
            m.s = wn == 1;
            m.r = wn == 1 ? r1 : r0;
            m.d = wn == 1 ? d1 : d0;
        end else if (m.k == 2 * w + a + d) begin
            m.k = 0;
            m.ha = 1'b1;
            m.hd = m.d;
        end else if (m.k != 0) begin
            m.k++;
        end
        return m;
    endfunction

    task automatic cmp_obs(input string p, input obs_t a, input obs_t e);
        chk({p, ".busy"}, a.busy, e.busy);
        chk({p, ".we"}, a.we, e.we);
        chk({p, ".addr"}, a.addr, e.addr);
        chk({p, ".din"}, a.din, e.din);
        chk({p, ".done"}, a.done, e.done);
        chk({p, ".src"}, a.src, e.src);
        chk({p, ".rdy0"}, a.rdy0, e.rdy0);
        chk({p, ".rdy1"}, a.rdy1, e.rdy1);
    endtask

    always @(negedge clk) begin : mon_a
        obs_t e, a;
        int wn;
        if (rst) ma = mdl_zero();
        wn = pick(ma, rst, ifa.req0_valid, ifa.req1_valid);
        e = expect_of(ma, 2, A_CYC, D_CYC, wn);
        a = {ifa.busy, ifa.opl_we, ifa.opl_addr, ifa.opl_din, ifa.wr_done, ifa.wr_src, ifa.req0_ready, ifa.req1_ready};
        cmp_obs("mdl_a", a, e);
        if (pa_we && ifa.opl_we) begin
            chk("a_we_stable_addr", ifa.opl_addr, pa_addr);
            chk("a_we_stable_din", ifa.opl_din, pa_din);
        end
        pa_we = ifa.opl_we; pa_addr = ifa.opl_addr; pa_din = ifa.opl_din;
        ma = step(ma, 2, A_CYC, D_CYC, rst, wn, ifa.req0_reg, ifa.req0_data, ifa.req1_reg, ifa.req1_data);
    end

    always @(negedge clk) begin : mon_z
        obs_t e, a;
        int wn;
        if (rst) mz = mdl_zero();
        wn = pick(mz, rst, ifz.req0_valid, ifz.req1_valid);
        e = expect_of(mz, 1, 1, 1, wn);
        a = {ifz.busy, ifz.opl_we, ifz.opl_addr, ifz.opl_din, ifz.wr_done, ifz.wr_src, ifz.req0_ready, ifz.req1_ready};
        cmp_obs("mdl_z", a, e);
        if (pz_we && ifz.opl_we) begin
            chk("z_we_stable_addr", ifz.opl_addr, pz_addr);
            chk("z_we_stable_din", ifz.opl_din, pz_din);
        end
        pz_we = ifz.opl_we; pz_addr = ifz.opl_addr; pz_din = ifz.opl_din;
        mz = step(mz, 1, 1, 1, rst, wn, ifz.req0_reg, ifz.req0_data, ifz.req1_reg, ifz.req1_data);
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
        ifz.req0_valid = 1'b0; ifz.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_rdy(input int who, input string n);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(who == 0 ? ifa.req0_ready : ifa.req1_ready) && c < 4000);
        chk(n, who == 0 ? ifa.req0_ready : ifa.req1_ready, 1);
    endtask

    task automatic wait_idle(input string n);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (ifa.busy && c < 4000);
        chk(n, ifa.busy, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        int   ph, hi1, lo1, hi2, lo2, done_k, who, last_done, c, zd;
        logic pw, src_v, bad, s0, s1;
        tbl[0]  = '{1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0};
        ifa.req0_valid = 1'b0; ifa.req0_reg = '0; ifa.req0_data = '0;
        ifa.req1_valid = 1'b0; ifa.req1_reg = '0; ifa.req1_data = '0;
        ifz.req0_valid = 1'b0; ifz.req0_reg = '0; ifz.req0_data = '0;
        ifz.req1_valid = 1'b0; ifz.req1_reg = '0; ifz.req1_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single write with full chip timing
        ifa.req0_reg = 8'h20; ifa.req0_data = 8'h01; ifa.req0_valid = 1'b1;
        wait_rdy(0, "t1_accept");
        @(posedge clk);
        #1 ifa.req0_valid = 1'b0;
        ph = 0; pw = 1'b1; hi1 = 0; lo1 = 0; hi2 = 0; lo2 = 0; done_k = 0; src_v = 1'b1;
        for (int k = 1; k <= 1894; k++) begin
            @(negedge clk);
            if (ifa.opl_we != pw) ph++;
            pw = ifa.opl_we;
            if (ph == 0) hi1++; else if (ph == 1) lo1++; else if (ph == 2) hi2++; else if (ph == 3) lo2++;
            if (k == 1) begin
                chk("t1_aph_addr", ifa.opl_addr, 0);
                chk("t1_aph_din", ifa.opl_din, 'h20);
            end
            if (k == 283) begin
                chk("t1_dph_addr", ifa.opl_addr, 1);
                chk("t1_dph_din", ifa.opl_din, 'h01);
            end
            if (ifa.wr_done) begin
                done_k = k;
                src_v = ifa.wr_src;
            end
        end
        chk("t1_we_hi1", hi1, 2);
        chk("t1_we_lo1", lo1, 280);
        chk("t1_we_hi2", hi2, 2);
        chk("t1_we_lo2", lo2, 1610);
        chk("t1_done_cycle", done_k, 1894);
        chk("t1_done_src", src_v, 0);
        wait_idle("t1_idle");

        // both requesters held valid: strict alternation, next accept right after wr_done
        do_reset();
        ifa.req0_reg = 8'hb0; ifa.req0_data = 8'hc1; ifa.req0_valid = 1'b1;
        ifa.req1_reg = 8'hb1; ifa.req1_data = 8'hc2; ifa.req1_valid = 1'b1;
        last_done = -1;
        for (int i = 0; i < 4; i++) begin
            who = -1; c = 0;
            while (who < 0 && c < 4000) begin
                @(negedge clk);
                c++;
                if (ifa.wr_done) last_done = cyc;
                if (ifa.req0_ready) who = 0; else if (ifa.req1_ready) who = 1;
            end
            chk("t2_order", who, i % 2);
            if (i > 0) chk("t2_gap_after_done", cyc - last_done, 1);
        end
        @(posedge clk);
        #1 ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
        wait_idle("t2_idle");

        // req1 arrives while busy: not ready until first idle cycle
        ifa.req0_reg = 8'h40; ifa.req0_data = 8'h3f; ifa.req0_valid = 1'b1;
        wait_rdy(0, "t3_acc0");
        @(posedge clk);
        #1 ifa.req0_valid = 1'b0;
        ifa.req1_reg = 8'ha0; ifa.req1_data = 8'h55; ifa.req1_valid = 1'b1;
        bad = 1'b0; c = 0;
        do begin
            @(negedge clk);
            c++;
            if (ifa.busy && ifa.req1_ready) bad = 1'b1;
        end while (ifa.busy && c < 4000);
        chk("t3_ready_while_busy", bad, 0);
        chk("t3_ready_first_idle", ifa.req1_ready, 1);
        @(posedge clk);
        #1 ifa.req1_valid = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (!ifa.opl_we && c < 100);
        chk("t3_req1_addr_port", ifa.opl_addr, 0);
        chk("t3_req1_reg", ifa.opl_din, 'ha0);
        c = 0;
        do begin @(negedge clk); c++; end while (!(ifa.opl_we && ifa.opl_addr) && c < 4000);
        chk("t3_req1_data", ifa.opl_din, 'h55);
        wait_idle("t3_idle");

        // asynchronous reset in the middle of DATA_WAIT
        ifa.req0_reg = 8'h08; ifa.req0_data = 8'h5a; ifa.req0_valid = 1'b1;
        wait_rdy(0, "t4_acc");
        @(posedge clk);
        #1 ifa.req0_valid = 1'b0;
        ifa.req1_reg = 8'h77; ifa.req1_data = 8'h66; ifa.req1_valid = 1'b1;
        repeat (384) @(negedge clk);
        chk("t4_in_data_wait", ifa.busy && !ifa.opl_we && ifa.opl_addr, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t4_rst_busy", ifa.busy, 0);
        chk("t4_rst_we", ifa.opl_we, 0);
        chk("t4_rst_done", ifa.wr_done, 0);
        chk("t4_rst_rdy1", ifa.req1_ready, 0);
        chk("t4_rst_din", ifa.opl_din, 0);
        chk("t4_rst_addr", ifa.opl_addr, 0);
        ifa.req0_reg = 8'h09; ifa.req0_data = 8'ha5; ifa.req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_ptr_req0", ifa.req0_ready, 1);
        chk("t4_ptr_not_req1", ifa.req1_ready, 0);
        @(posedge clk);
        #1 ifa.req0_valid = 1'b0;
        wait_rdy(1, "t4_acc1");
        @(posedge clk);
        #1 ifa.req1_valid = 1'b0;
        wait_idle("t4_idle");

        // zero-wait instance: cycle-exact vector table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1 ifz.req0_valid = tbl[i].v;
            if (tbl[i].v) begin
                ifz.req0_reg = tbl[i].r;
                ifz.req0_data = tbl[i].d;
            end
            @(negedge clk);
            chk($sformatf("z%0d.rdy0", i), ifz.req0_ready, tbl[i].rdy);
            chk($sformatf("z%0d.we", i), ifz.opl_we, tbl[i].we);
            chk($sformatf("z%0d.addr", i), ifz.opl_addr, tbl[i].addr);
            chk($sformatf("z%0d.din", i), ifz.opl_din, tbl[i].din);
            chk($sformatf("z%0d.done", i), ifz.wr_done, tbl[i].done);
            chk($sformatf("z%0d.busy", i), ifz.busy, tbl[i].busy);
            chk($sformatf("z%0d.src", i), ifz.wr_src, 0);
        end

        // randomized requests on the zero-wait instance
        zd = 0;
        for (int c2 = 0; c2 < 40000 && zd < 1000; c2++) begin
            @(negedge clk);
            s0 = ifz.req0_ready;
            s1 = ifz.req1_ready;
            if (ifz.wr_done) zd++;
            @(posedge clk);
            #1;
            if (s0) ifz.req0_valid = 1'b0;
            if (s1) ifz.req1_valid = 1'b0;
            if (!ifz.req0_valid && $urandom_range(0, 1) == 0) begin
                ifz.req0_valid = 1'b1;
                ifz.req0_reg = 8'($urandom);
                ifz.req0_data = 8'($urandom);
            end
            if (!ifz.req1_valid && $urandom_range(0, 1) == 0) begin
                ifz.req1_valid = 1'b1;
                ifz.req1_reg = 8'($urandom);
                ifz.req1_data = 8'($urandom);
            end
        end
        chk("z_random_1000_done", zd >= 1000, 1);
        ifz.req0_valid = 1'b0;
        ifz.req1_valid = 1'b0;
        repeat (10) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/opl2_write_sched.md
Name: opl2_write_sched

Overview:
Sequences OPL2 register writes onto the two-phase address/data write port of the OPL2 interface block. It arbitrates round-robin between two requesters: requester 0 is the CPU port-write path, requester 1 is the music/IMF player. Each accepted request becomes an address-phase write, a data-phase write and the mandatory chip wait times. The block sits between the requesters and the OPL2 interface write port, which edge-detects its write strobe.

Parameters:
CLK_DIV, 70, clk cycles per microsecond (70 MHz system clock)
WE_CYCLES, 2, clk cycles opl_we is held high per phase (>=1)
ADDR_WAIT_US, 4, microseconds after the address phase before the data phase
DATA_WAIT_US, 23, microseconds after the data phase before the next write

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 (CPU) write request
req0_reg  in  8  requester 0 register number
req0_data  in  8  requester 0 register value
req0_ready  out  1  requester 0 accepted this cycle (valid&ready)
req1_valid  in  1  requester 1 (player) write request
req1_reg  in  8  requester 1 register number
req1_data  in  8  requester 1 register value
req1_ready  out  1  requester 1 accepted this cycle
opl_addr  out  1  0 = address port, 1 = data port
opl_din  out  8  byte to the OPL2 interface
opl_we  out  1  write strobe (downstream detects the rising edge)
busy  out  1  high whenever state != IDLE
wr_done  out  1  one-cycle pulse when a write sequence completes
wr_src  out  1  requester id of the completed write, valid with wr_done

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset value of all outputs is 0. After reset: state IDLE, round-robin pointer favours req0, counters cleared.
- States: IDLE -> ADDR_PH -> ADDR_WAIT -> DATA_PH -> DATA_WAIT -> IDLE.
- IDLE arbitration:
  - reqN_ready is combinational and is only ever high in IDLE, for at most one requester.
  - One valid requester: it wins.
  - Both valid: the pointer picks the winner.
  - Handshake (valid & ready): latch reg/data/src, set the pointer to the other requester, go to ADDR_PH next cycle.
  - A requester must hold valid and payload stable until ready.
- ADDR_PH: opl_addr=0, opl_din=latched reg, opl_we=1 for exactly WE_CYCLES cycles.
- ADDR_WAIT: opl_we=0, opl_addr and opl_din held. Lasts max(1, ADDR_WAIT_US*CLK_DIV) cycles. The cycle counter reloads on state entry, so there is no free-running prescaler phase error.
- DATA_PH: opl_addr=1, opl_din=latched data, opl_we=1 for WE_CYCLES cycles.
- DATA_WAIT: opl_we=0, outputs held, max(1, DATA_WAIT_US*CLK_DIV) cycles. On the last cycle, pulse wr_done with wr_src and return to IDLE.
- Timing: opl_we is low for >=1 cycle between phases, so each phase produces a rising edge. Accept-to-IDLE is 2*WE_CYCLES + waits cycles. The next accept can occur in the first IDLE cycle, so back-to-back writes have no extra idle gap.
- Width rule: the wait counter is sized $clog2(max(ADDR_WAIT_US,DATA_WAIT_US)*CLK_DIV+1). Constants are computed as 32-bit integers and then truncated.
- A request arriving while busy is not accepted; no queueing. A requester starves at most one sequence.
- Reset mid-sequence: immediate return to IDLE, opl_we=0, and no wr_done. A half-written address latch in the chip is tolerated; the next write rewrites the address.
- Zero wait parameters still give a 1-cycle wait state.

Decomposition:
- Package opl2_pkg holds:
  - state enum typedef sched_state_t (IDLE, ADDR_PH, ADDR_WAIT, DATA_PH, DATA_WAIT);
  - constants OPL2_ADDR_WAIT_US=4, OPL2_DATA_WAIT_US=23, OPL2_CLK_DIV=70;
  - typedef opl2_wr_t {reg[7:0], data[7:0], src}.
- One sub-module, opl2_rr_arb2: two-requester round-robin grant with pointer update on accept.
- The wait/strobe counter stays inline in the FSM.

Test Plan:
- Reset then req0 write reg 0x20 data 0x01 -> opl_we high 2 cycles with addr=0/din=0x20, then 280 cycles low, then 2 cycles high with addr=1/din=0x01, then 1610 cycles low, then wr_done=1 and wr_src=0. Total 1894 cycles.
- req0 and req1 valid together in IDLE after reset -> req0 served first, then req1 accepted the cycle after wr_done. Repeat with both held valid -> strict alternation 0,1,0,1.
- req1 valid while busy serving req0 -> req1_ready stays 0 throughout and is asserted in the first IDLE cycle. Payload observed on opl_din matches req1.
- rst asserted mid-DATA_WAIT -> opl_we, busy, wr_done and ready all go 0 asynchronously. After release, the first request proceeds with full timing and the pointer favours req0.
- Parameter override ADDR_WAIT_US=0, DATA_WAIT_US=0, WE_CYCLES=1 -> the strobe pattern is 1,0,1,0 with distinct rising edges and a 4-cycle sequence.
- Monitor on opl_we: every rising edge has stable opl_addr/opl_din from one cycle before the edge until opl_we falls. Check this across 1000 random requests.
